alu_uart_interface: RTL and testbench

//   Upstream control stage for the ALU: collects operand A, operand B and opcode
//   as three consecutive bytes from the UART receiver, and presents them on

---
 rtl/alu_uart_interface.sv | 175 +++++++++++++++++
 tb/tb_alu_uart_interface.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_interface.sv
// alu_uart_interface
//   Upstream control stage for the ALU. Collects operand A, operand B and the
//   opcode as three consecutive UART bytes and drives them to the ALU from
//   registers. It then latches the ALU result and flags and hands them back to
//   the UART transmitter as two bytes: the result first, then the flags byte.
//
//   State table
//     state    | meaning
//     ---------+----------------------------------------------------------
//     S_IDLE   | waiting for operand A byte
//     S_WAIT_B | waiting for operand B byte (inter-byte timeout armed)
//     S_WAIT_OP| waiting for opcode byte (inter-byte timeout armed)
//     S_EXEC   | ALU inputs settled; latch result/flags, start result byte
//     S_SEND_RES| result byte in flight; on i_tx_done start flags byte
//     S_SEND_FLG| flags byte in flight; on i_tx_done return to idle
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset       synchronous active-high reset
//   i_rx_data     received byte, valid with i_rx_done
//   i_rx_done     one-cycle strobe from the UART receiver
//   i_tx_done     one-cycle strobe from the UART transmitter
//   i_alu_result  combinational ALU result
//   i_alu_flags   {exception,negative,overflow,carry,zero}
//   o_operandA/B  registered ALU operands
//   o_opcode      registered ALU opcode
//   o_tx_data     byte to transmit
//   o_tx_start    one-cycle strobe to start the transmitter
//   o_busy        high whenever not in S_IDLE
//   o_timeout     one-cycle strobe: partial frame discarded

module alu_uart_interface #(
    parameter int DATA_WIDTH     = 8,
    parameter int OPCODE_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_done,
    input  logic                    i_tx_done,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    input  logic [4:0]              i_alu_flags,
    output logic [DATA_WIDTH-1:0]   o_operandA,
    output logic [DATA_WIDTH-1:0]   o_operandB,
    output logic [OPCODE_WIDTH-1:0] o_opcode,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_busy,
    output logic                    o_timeout
);

    // A zero TIMEOUT_CYCLES disables the timeout; keep the counter at least one
    // bit wide so the design still elaborates in that case.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_B   = 3'd1,
        S_WAIT_OP  = 3'd2,
        S_EXEC     = 3'd3,
        S_SEND_RES = 3'd4,
        S_SEND_FLG = 3'd5
    } state_t;

    state_t                  state_q,    state_d;
    logic [DATA_WIDTH-1:0]   op_a_q,     op_a_d;
    logic [DATA_WIDTH-1:0]   op_b_q,     op_b_d;
    logic [OPCODE_WIDTH-1:0] opcode_q,   opcode_d;
    logic [4:0]              flags_q,    flags_d;
    logic [7:0]              tx_data_q,  tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic                    timeout_q,  timeout_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        opcode_d   = opcode_q;
        flags_d    = flags_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        cnt_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (i_rx_done) begin
                    op_a_d  = DATA_WIDTH'(i_rx_data);
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                // A byte arriving in the expiry cycle takes priority over the timeout.
                if (i_rx_done) begin
                    op_b_d  = DATA_WIDTH'(i_rx_data);
                    state_d = S_WAIT_OP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_OP: begin
                if (i_rx_done) begin
                    opcode_d = i_rx_data[OPCODE_WIDTH-1:0];
                    state_d  = S_EXEC;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                flags_d    = i_alu_flags;
                tx_data_d  = 8'(i_alu_result);
                tx_start_d = 1'b1;
                state_d    = S_SEND_RES;
            end
            S_SEND_RES: begin
                if (i_tx_done) begin
                    tx_data_d  = {3'b000, flags_q};
                    tx_start_d = 1'b1;
                    state_d    = S_SEND_FLG;
                end
            end
            S_SEND_FLG: begin
                if (i_tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            opcode_q   <= '0;
            flags_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            opcode_q   <= opcode_d;
            flags_q    <= flags_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_operandA = op_a_q;
    assign o_operandB = op_b_q;
    assign o_opcode   = opcode_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_timeout  = timeout_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_uart_interface.sv
// tb_alu_uart_interface
//   Directed bench for alu_uart_interface with TIMEOUT_CYCLES=16. The ALU is a
//   stub: the bench drives i_alu_result / i_alu_flags with fixed values.
//   Inputs change 1 ns after a rising edge; outputs are checked at that point.

module tb_alu_uart_interface;

    logic       i_clock;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] i_alu_result;
    logic [4:0] i_alu_flags;
    logic [7:0] o_operandA;
    logic [7:0] o_operandB;
    logic [3:0] o_opcode;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_uart_interface #(
        .DATA_WIDTH     (8),
        .OPCODE_WIDTH   (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .i_tx_done    (i_tx_done),
        .i_alu_result (i_alu_result),
        .i_alu_flags  (i_alu_flags),
        .o_operandA   (o_operandA),
        .o_operandB   (o_operandB),
        .o_opcode     (o_opcode),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic tx_ack();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        total_cnt++;
        if ({o_operandA, o_operandB, o_opcode, o_tx_data, o_tx_start, o_busy, o_timeout} !== 36'd0) begin
            $display("FAIL reset_outputs: got A=%h B=%h op=%h tx=%h st=%b busy=%b to=%b, want all 0",
                     o_operandA, o_operandB, o_opcode, o_tx_data, o_tx_start, o_busy, o_timeout);
        end else pass_cnt++;
        // A stray transmitter strobe while idle must be ignored.
        tx_ack();
        total_cnt++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
            $display("FAIL idle_tx_done: busy=%b tx_start=%b, want 0/0", o_busy, o_tx_start);
        end else pass_cnt++;
    endtask

    task automatic test_basic_frame();
        i_alu_result = 8'h08;
        i_alu_flags  = 5'b00000;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h08);
        total_cnt++;
        if (o_operandA !== 8'h05 || o_operandB !== 8'h03 || o_opcode !== 4'h8) begin
            $display("FAIL basic_operands: A=%h B=%h op=%h, want 05 03 8", o_operandA, o_operandB, o_opcode);
        end else pass_cnt++;
        total_cnt++;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
            $display("FAIL basic_exec: tx_start=%b busy=%b, want 0/1", o_tx_start, o_busy);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h08) begin
            $display("FAIL basic_result_byte: tx_start=%b data=%h, want 1/08", o_tx_start, o_tx_data);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (o_tx_start !== 1'b0 || o_tx_data !== 8'h08) begin
            $display("FAIL basic_start_pulse: tx_start=%b data=%h, want 0/08", o_tx_start, o_tx_data);
        end else pass_cnt++;
        tx_ack();
        total_cnt++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h00) begin
            $display("FAIL basic_flags_byte: tx_start=%b data=%h, want 1/00", o_tx_start, o_tx_data);
        end else pass_cnt++;
        tick();
        tx_ack();
        total_cnt++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
            $display("FAIL basic_done: busy=%b tx_start=%b, want 0/0", o_busy, o_tx_start);
        end else pass_cnt++;
    endtask

    task automatic test_opcode_mask();
        i_alu_result = 8'h80;
        i_alu_flags  = 5'b00110;
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'h18);
        total_cnt++;
        if (o_opcode !== 4'h8 || o_operandA !== 8'h7F || o_operandB !== 8'h01) begin
            $display("FAIL mask_opcode: op=%h A=%h B=%h, want 8 7f 01", o_opcode, o_operandA, o_operandB);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h80) begin
            $display("FAIL mask_result_byte: tx_start=%b data=%h, want 1/80", o_tx_start, o_tx_data);
        end else pass_cnt++;
        tx_ack();
        total_cnt++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h06) begin
            $display("FAIL mask_flags_byte: tx_start=%b data=%h, want 1/06", o_tx_start, o_tx_data);
        end else pass_cnt++;
        tx_ack();
        total_cnt++;
        if (o_busy !== 1'b0) begin
            $display("FAIL mask_done: busy=%b, want 0", o_busy);
        end else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n = 0;
        send_byte(8'hAA);
        for (int i = 1; i <= 40 && n == 0; i++) begin
            tick();
            if (o_timeout === 1'b1) n = i;
        end
        total_cnt++;
        if (n != 16) begin
            $display("FAIL timeout_latency: pulse after %0d idle cycles, want 16 (0 = none)", n);
        end else pass_cnt++;
        total_cnt++;
        if (o_busy !== 1'b0 || o_operandA !== 8'hAA) begin
            $display("FAIL timeout_state: busy=%b A=%h, want 0/aa", o_busy, o_operandA);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (o_timeout !== 1'b0) begin
            $display("FAIL timeout_pulse_width: timeout=%b, want 0", o_timeout);
        end else pass_cnt++;
        send_byte(8'h11);
        total_cnt++;
        if (o_operandA !== 8'h11 || o_busy !== 1'b1) begin
            $display("FAIL timeout_next_a: A=%h busy=%b, want 11/1", o_operandA, o_busy);
        end else pass_cnt++;
    endtask

    task automatic test_expiry_race();
        logic tout_seen = 1'b0;
        // Entered WAIT_B one edge ago with counter 0; after 15 more edges the
        // counter sits at 15, which is the expiry cycle.
        for (int i = 0; i < 15; i++) begin
            tick();
            if (o_timeout === 1'b1) tout_seen = 1'b1;
        end
        send_byte(8'h22);
        total_cnt++;
        if (o_operandB !== 8'h22 || o_operandA !== 8'h11 || o_busy !== 1'b1) begin
            $display("FAIL race_byte_taken: A=%h B=%h busy=%b, want 11 22 1", o_operandA, o_operandB, o_busy);
        end else pass_cnt++;
        total_cnt++;
        if (o_timeout !== 1'b0 || tout_seen !== 1'b0) begin
            $display("FAIL race_no_timeout: timeout=%b earlier=%b, want 0/0", o_timeout, tout_seen);
        end else pass_cnt++;
        i_alu_result = 8'h33;
        i_alu_flags  = 5'b00000;
        send_byte(8'h03);
        tick();
        total_cnt++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h33 || o_opcode !== 4'h3) begin
            $display("FAIL race_result: tx_start=%b data=%h op=%h, want 1 33 3", o_tx_start, o_tx_data, o_opcode);
        end else pass_cnt++;
        tx_ack();
        tx_ack();
        total_cnt++;
        if (o_busy !== 1'b0) begin
            $display("FAIL race_done: busy=%b, want 0", o_busy);
        end else pass_cnt++;
    endtask

    task automatic test_rx_during_send();
        i_alu_result = 8'h23;
        i_alu_flags  = 5'b00001;
        send_byte(8'h21);
        send_byte(8'h02);
        send_byte(8'h01);
        tick();
        send_byte(8'h55);
        total_cnt++;
        if (o_operandA !== 8'h21 || o_tx_data !== 8'h23 || o_busy !== 1'b1) begin
            $display("FAIL drop_rx: A=%h data=%h busy=%b, want 21 23 1", o_operandA, o_tx_data, o_busy);
        end else pass_cnt++;
        tx_ack();
        total_cnt++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h01) begin
            $display("FAIL drop_flags_byte: tx_start=%b data=%h, want 1/01", o_tx_start, o_tx_data);
        end else pass_cnt++;
        tx_ack();
        total_cnt++;
        if (o_busy !== 1'b0 || o_operandA !== 8'h21) begin
            $display("FAIL drop_done: busy=%b A=%h, want 0/21", o_busy, o_operandA);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_send();
        i_alu_result = 8'h1E;
        i_alu_flags  = 5'b10001;
        send_byte(8'h0F);
        send_byte(8'h0F);
        send_byte(8'h02);
        tick();
        tx_ack();
        total_cnt++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h11) begin
            $display("FAIL rst_flags_byte: tx_start=%b data=%h, want 1/11", o_tx_start, o_tx_data);
        end else pass_cnt++;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        total_cnt++;
        if ({o_operandA, o_operandB, o_opcode, o_tx_data, o_tx_start, o_busy, o_timeout} !== 36'd0) begin
            $display("FAIL rst_mid_send: got A=%h B=%h op=%h tx=%h st=%b busy=%b to=%b, want all 0",
                     o_operandA, o_operandB, o_opcode, o_tx_data, o_tx_start, o_busy, o_timeout);
        end else pass_cnt++;
        // Flags must have been cleared too: a zero-flag frame sends 0x00.
        i_alu_result = 8'h03;
        i_alu_flags  = 5'b00000;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h00);
        tick();
        total_cnt++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h03) begin
            $display("FAIL rst_fresh_result: tx_start=%b data=%h, want 1/03", o_tx_start, o_tx_data);
        end else pass_cnt++;
        tx_ack();
        total_cnt++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h00) begin
            $display("FAIL rst_fresh_flags: tx_start=%b data=%h, want 1/00", o_tx_start, o_tx_data);
        end else pass_cnt++;
        tx_ack();
        total_cnt++;
        if (o_busy !== 1'b0) begin
            $display("FAIL rst_fresh_done: busy=%b, want 0", o_busy);
        end else pass_cnt++;
    endtask

    initial begin
        i_reset      = 1'b1;
        i_rx_data    = 8'h00;
        i_rx_done    = 1'b0;
        i_tx_done    = 1'b0;
        i_alu_result = 8'h00;
        i_alu_flags  = 5'b00000;
        test_reset();
        test_basic_frame();
        test_opcode_mask();
        test_timeout();
        test_expiry_race();
        test_rx_during_send();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
